// File: rtl/nanov_instr_fetch_pkg.sv
// Shared constants, FSM state type and helpers for the nanoV instruction fetch stage.
package nanov_instr_fetch_pkg;

  localparam logic [7:0]  SPI_CMD_READ    = 8'h03;
  localparam int unsigned CMD_BITS        = 8;
  localparam int unsigned ADDR_FIELD_BITS = 24;
  localparam int unsigned WORD_BITS       = 32;
  localparam int unsigned BIT_CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_CMD,
    ST_ADDR,
    ST_DATA
  } fetch_state_e;

  // Bits arrive byte by byte, MSB first; the first byte is the least significant.
  function automatic logic [WORD_BITS-1:0] word_from_flash(input logic [WORD_BITS-1:0] sr);
    return {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
  endfunction

endpackage

// File: rtl/nanov_fetch_buffer.sv
// Two-entry prefetch buffer: current and next instruction words with promotion.
module nanov_fetch_buffer
  import nanov_instr_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic                 consume_req,
  output logic [WORD_BITS-1:0] instr,
  output logic                 instr_valid,
  output logic [WORD_BITS-1:0] next_instr,
  output logic                 next_valid,
  output logic                 consume_c,
  output logic                 full_next_c
);

  logic [WORD_BITS-1:0] instr_d;
  logic [WORD_BITS-1:0] next_d;
  logic                 instr_valid_d;
  logic                 next_valid_d;

  assign consume_c = consume_req & instr_valid;

  // Next slot contents: flush wins, then promotion, then the new word fills the first free slot.
  always_comb begin
    instr_d       = instr;
    next_d        = next_instr;
    instr_valid_d = instr_valid;
    next_valid_d  = next_valid;
    if (flush) begin
      instr_valid_d = 1'b0;
      next_valid_d  = 1'b0;
    end else begin
      if (consume_c) begin
        instr_d       = next_instr;
        instr_valid_d = next_valid;
        next_valid_d  = 1'b0;
      end
      if (wr_en) begin
        if (!instr_valid_d) begin
          instr_d       = wr_word;
          instr_valid_d = 1'b1;
        end else begin
          next_d       = wr_word;
          next_valid_d = 1'b1;
        end
      end
    end
  end

  assign full_next_c = instr_valid_d & next_valid_d;

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      next_instr  <= '0;
      instr_valid <= 1'b0;
      next_valid  <= 1'b0;
    end else begin
      instr       <= instr_d;
      next_instr  <= next_d;
      instr_valid <= instr_valid_d;
      next_valid  <= next_valid_d;
    end
  end

endmodule

// File: rtl/nanov_instr_fetch.sv
// SPI flash instruction fetch: READ command, streaming words into a 2-entry buffer.
module nanov_instr_fetch
  import nanov_instr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_BITS     = 24,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR    = '0,
  parameter int unsigned          CS_GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 spi_select,
  output logic                 spi_clk_en,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  input  logic                 branch,
  input  logic [ADDR_BITS-1:0] branch_target,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic                 instr_valid,
  output logic [31:0]          next_instr,
  output logic                 next_valid,
  output logic [ADDR_BITS-1:0] pc
);

  localparam int unsigned          GAP_W      = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(CS_GAP_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(3);
  localparam logic [ADDR_BITS-1:0] WORD_STEP  = ADDR_BITS'(4);
  localparam logic [BIT_CNT_W-1:0] CMD_LAST   = BIT_CNT_W'(CMD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] ADDR_LAST  = BIT_CNT_W'(ADDR_FIELD_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] WORD_LAST  = BIT_CNT_W'(WORD_BITS - 1);

  fetch_state_e                 state;
  logic [GAP_W-1:0]             gap_cnt;
  logic [BIT_CNT_W-1:0]         bit_cnt;
  logic [ADDR_BITS-1:0]         fetch_addr;
  logic [WORD_BITS-1:0]         tx_sr;
  logic [WORD_BITS-2:0]         rx_sr;

  logic [WORD_BITS-1:0]         rx_shift_c;
  logic [WORD_BITS-1:0]         tx_load_c;
  logic [ADDR_BITS-1:0]         target_c;
  logic                         word_done_c;
  logic                         consume_c;
  logic                         full_next_c;

  assign rx_shift_c  = {rx_sr, spi_miso};
  assign tx_load_c   = {SPI_CMD_READ, ADDR_FIELD_BITS'(fetch_addr & ALIGN_MASK)};
  assign target_c    = branch_target & ALIGN_MASK;
  assign word_done_c = (state == ST_DATA) && spi_clk_en && (bit_cnt == WORD_LAST);

  nanov_fetch_buffer u_buffer (
    .clk         (clk),
    .rst         (rst),
    .flush       (branch),
    .wr_en       (word_done_c),
    .wr_word     (word_from_flash(rx_shift_c)),
    .consume_req (instr_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .next_instr  (next_instr),
    .next_valid  (next_valid),
    .consume_c   (consume_c),
    .full_next_c (full_next_c)
  );

  // Fetch FSM; SPI outputs are registered to describe the coming SCK period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      fetch_addr <= RESET_ADDR & ALIGN_MASK;
      tx_sr      <= '0;
      rx_sr      <= '0;
      spi_select <= 1'b1;
      spi_clk_en <= 1'b0;
      spi_mosi   <= 1'b0;
      pc         <= RESET_ADDR;
    end else if (branch) begin
      state      <= ST_GAP;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      fetch_addr <= target_c;
      pc         <= target_c;
      spi_select <= 1'b1;
      spi_clk_en <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      if (consume_c) pc <= pc + WORD_STEP;
      unique case (state)
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= ST_CMD;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            spi_select <= 1'b0;
            spi_clk_en <= 1'b1;
            spi_mosi   <= tx_load_c[WORD_BITS-1];
            tx_sr      <= {tx_load_c[WORD_BITS-2:0], 1'b0};
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_CMD: begin
          spi_mosi <= tx_sr[WORD_BITS-1];
          tx_sr    <= {tx_sr[WORD_BITS-2:0], 1'b0};
          if (bit_cnt == CMD_LAST) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            state      <= ST_DATA;
            bit_cnt    <= '0;
            spi_mosi   <= 1'b0;
            spi_clk_en <= !full_next_c;
          end else begin
            spi_mosi <= tx_sr[WORD_BITS-1];
            tx_sr    <= {tx_sr[WORD_BITS-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          spi_mosi <= 1'b0;
          if (spi_clk_en) begin
            rx_sr <= rx_shift_c[WORD_BITS-2:0];
            if (bit_cnt == WORD_LAST) begin
              // Word boundary: pause SCK if the buffer will be full.
              bit_cnt    <= '0;
              fetch_addr <= fetch_addr + WORD_STEP;
              spi_clk_en <= !full_next_c;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            spi_clk_en <= !full_next_c;
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_instr_fetch.sv
// Directed bench for nanov_instr_fetch with a behavioural SPI flash per DUT.
module tb_nanov_instr_fetch;

  logic        clk = 1'b0;
  logic [1:0]  sel, en, mosi, miso;

  logic        rst0, rst1;
  logic        branch0, branch1, ready0, ready1;
  logic [23:0] target0, target1;
  logic [31:0] instr0, instr1, next0, next1;
  logic        iv0, iv1, nv0, nv1;
  logic [23:0] pc0, pc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nanov_instr_fetch #(.ADDR_BITS(24), .RESET_ADDR(24'h000000), .CS_GAP_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst0), .spi_select(sel[0]), .spi_clk_en(en[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .branch(branch0), .branch_target(target0), .instr_ready(ready0),
    .instr(instr0), .instr_valid(iv0), .next_instr(next0), .next_valid(nv0), .pc(pc0)
  );

  nanov_instr_fetch #(.ADDR_BITS(24), .RESET_ADDR(24'hFFFFFC), .CS_GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst1), .spi_select(sel[1]), .spi_clk_en(en[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1]), .branch(branch1), .branch_target(target1), .instr_ready(ready1),
    .instr(instr1), .instr_valid(iv1), .next_instr(next1), .next_valid(nv1), .pc(pc1)
  );

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000000: return 32'h00000013;
      24'h000004: return 32'h00A00093;
      default:    return 32'hC0000000 | 32'(a);
    endcase
  endfunction

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] w;
    w = flash_word({a[23:2], 2'b00});
    return 8'(w >> (8 * 32'(a[1:0])));
  endfunction

  // Flash model: 8 command + 24 address bits, then sequential bytes MSB first.
  for (genvar g = 0; g < 2; g++) begin : g_flash
    int unsigned cnt;
    logic [31:0] sh;
    logic [31:0] hdr;
    logic        bit_c;
    always @(posedge clk) begin
      if (sel[g]) begin
        cnt <= 0;
      end else if (en[g]) begin
        if (cnt < 32) sh <= {sh[30:0], mosi[g]};
        if (cnt == 31) hdr <= {sh[30:0], mosi[g]};
        cnt <= cnt + 1;
      end
    end
    always_comb begin
      int unsigned k;
      logic [7:0]  b;
      bit_c = 1'b0;
      k = 0;
      b = 8'h00;
      if (cnt >= 32) begin
        k = cnt - 32;
        b = flash_byte(sh[23:0] + 24'(k >> 3));
        bit_c = b[7 - (k & 7)];
      end
    end
    assign miso[g] = bit_c;
  end

  typedef struct {
    int unsigned adv;
    logic        rst;
    logic        ready;
    logic        branch;
    logic [23:0] target;
    logic        sel;
    logic        en;
    logic        iv;
    logic [31:0] instr;
    logic        nv;
    logic [31:0] next;
    logic [23:0] pc;
    logic        chk_all;
    logic        chk_hdr;
    logic [31:0] hdr;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    //            adv rst rdy br  target       sel en iv instr         nv next          pc           all hdrchk hdr
    vecs[0]  = '{1,   0,  0,  0,  24'h000000,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000000,  0, 0, 32'h0};
    vecs[1]  = '{1,   0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000000,  0, 0, 32'h0};
    vecs[2]  = '{64,  0,  0,  0,  24'h000000,  0,  1, 1, 32'h00000013, 0, 32'h0,        24'h000000,  0, 1, 32'h03000000};
    vecs[3]  = '{31,  0,  0,  0,  24'h000000,  0,  1, 1, 32'h00000013, 0, 32'h0,        24'h000000,  0, 0, 32'h0};
    vecs[4]  = '{1,   0,  0,  0,  24'h000000,  0,  0, 1, 32'h00000013, 1, 32'h00A00093, 24'h000000,  0, 0, 32'h0};
    vecs[5]  = '{200, 0,  0,  0,  24'h000000,  0,  0, 1, 32'h00000013, 1, 32'h00A00093, 24'h000000,  0, 0, 32'h0};
    vecs[6]  = '{1,   0,  1,  0,  24'h000000,  0,  1, 1, 32'h00A00093, 0, 32'h0,        24'h000004,  0, 0, 32'h0};
    vecs[7]  = '{32,  0,  0,  0,  24'h000000,  0,  0, 1, 32'h00A00093, 1, 32'hC0000008, 24'h000004,  0, 0, 32'h0};
    vecs[8]  = '{10,  0,  1,  0,  24'h000000,  0,  1, 1, 32'hC0000008, 0, 32'h0,        24'h000008,  0, 0, 32'h0};
    vecs[9]  = '{1,   0,  0,  1,  24'h000123,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000120,  0, 0, 32'h0};
    vecs[10] = '{1,   0,  0,  0,  24'h000000,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000120,  0, 0, 32'h0};
    vecs[11] = '{1,   0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000120,  0, 0, 32'h0};
    vecs[12] = '{63,  0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000120,  0, 0, 32'h0};
    vecs[13] = '{1,   0,  0,  0,  24'h000000,  0,  1, 1, 32'hC0000120, 0, 32'h0,        24'h000120,  0, 1, 32'h03000120};
    vecs[14] = '{31,  0,  0,  0,  24'h000000,  0,  1, 1, 32'hC0000120, 0, 32'h0,        24'h000120,  0, 0, 32'h0};
    vecs[15] = '{1,   0,  1,  1,  24'h000200,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000200,  0, 0, 32'h0};
    vecs[16] = '{65,  0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000200,  0, 0, 32'h0};
    vecs[17] = '{1,   0,  0,  0,  24'h000000,  0,  1, 1, 32'hC0000200, 0, 32'h0,        24'h000200,  0, 1, 32'h03000200};
    vecs[18] = '{1,   0,  0,  1,  24'h000043,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000040,  0, 0, 32'h0};
    vecs[19] = '{13,  0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000040,  0, 0, 32'h0};
    vecs[20] = '{1,   1,  0,  0,  24'h000000,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000000,  1, 1, 32'h03000200};
    vecs[21] = '{1,   0,  0,  0,  24'h000000,  1,  0, 0, 32'h0,        0, 32'h0,        24'h000000,  0, 0, 32'h0};
    vecs[22] = '{1,   0,  0,  0,  24'h000000,  0,  1, 0, 32'h0,        0, 32'h0,        24'h000000,  0, 0, 32'h0};
    vecs[23] = '{64,  0,  0,  0,  24'h000000,  0,  1, 1, 32'h00000013, 0, 32'h0,        24'h000000,  0, 1, 32'h03000000};

    rst0 = 1'b1; rst1 = 1'b1;
    branch0 = 1'b0; branch1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    target0 = '0; target1 = '0;
    repeat (3) tick();
    rst0 = 1'b0;

    // Reset state of DUT0.
    check("reset sel", 32'(sel[0]), 32'h1);
    check("reset clk_en", 32'(en[0]), 32'h0);
    check("reset mosi", 32'(mosi[0]), 32'h0);
    check("reset instr_valid", 32'(iv0), 32'h0);
    check("reset next_valid", 32'(nv0), 32'h0);
    check("reset instr", instr0, 32'h0);
    check("reset next_instr", next0, 32'h0);
    check("reset pc", 32'(pc0), 32'h0);

    for (int i = 0; i < NV; i++) begin
      rst0    = vecs[i].rst;
      ready0  = vecs[i].ready;
      branch0 = vecs[i].branch;
      target0 = vecs[i].target;
      tick();
      rst0 = 1'b0; ready0 = 1'b0; branch0 = 1'b0; target0 = '0;
      repeat (vecs[i].adv - 1) tick();
      check($sformatf("row%0d spi_select", i), 32'(sel[0]), 32'(vecs[i].sel));
      check($sformatf("row%0d spi_clk_en", i), 32'(en[0]), 32'(vecs[i].en));
      check($sformatf("row%0d instr_valid", i), 32'(iv0), 32'(vecs[i].iv));
      check($sformatf("row%0d next_valid", i), 32'(nv0), 32'(vecs[i].nv));
      check($sformatf("row%0d pc", i), 32'(pc0), 32'(vecs[i].pc));
      if (vecs[i].iv || vecs[i].chk_all)
        check($sformatf("row%0d instr", i), instr0, vecs[i].instr);
      if (vecs[i].nv || vecs[i].chk_all)
        check($sformatf("row%0d next_instr", i), next0, vecs[i].next);
      if (vecs[i].chk_hdr)
        check($sformatf("row%0d flash cmd+addr", i), g_flash[0].hdr, vecs[i].hdr);
    end

    // Wrap from the top word of the address space.
    rst1 = 1'b0;
    repeat (66) tick();
    check("wrap first valid", 32'(iv1), 32'h1);
    check("wrap first pc", 32'(pc1), 32'h00FFFFFC);
    check("wrap first instr", instr1, 32'hC0FFFFFC);
    check("wrap cmd+addr", g_flash[1].hdr, 32'h03FFFFFC);
    repeat (32) tick();
    check("wrap second valid", 32'(nv1), 32'h1);
    check("wrap second word", next1, 32'h00000013);
    check("wrap stall", 32'(en[1]), 32'h0);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    check("wrap pc to zero", 32'(pc1), 32'h0);
    check("wrap promoted instr", instr1, 32'h00000013);
    check("wrap next cleared", 32'(nv1), 32'h0);
    repeat (32) tick();
    check("wrap third word", next1, 32'h00A00093);
    check("wrap third valid", 32'(nv1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nanov_instr_fetch.md
Name: nanov_instr_fetch

Overview:
- Instruction fetch stage directly upstream of the nanoV core.
- Streams 32-bit instruction words from a SPI flash using the READ command (0x03) and holds them in a 2-entry prefetch buffer.
- Presents the current instruction, the prefetched next instruction and the current PC to the core.
- Flushes the buffer and re-addresses the flash when the core signals a taken branch or jump.

Parameters:
ADDR_BITS, 24, width of the flash byte address and of the PC.
RESET_ADDR, 0, byte address of the first fetch after reset; must be word aligned.
CS_GAP_CYCLES, 2, minimum number of cycles spi_select is held high between transactions (at least 1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
spi_select  output  1  flash chip select, active low
spi_clk_en  output  1  high = one SCK period this cycle; external logic gates SCK from clk
spi_mosi  output  1  command/address bit for this SCK period
spi_miso  input  1  flash data bit, sampled at posedge clk when spi_clk_en=1
branch  input  1  taken branch/jump; single-cycle pulse
branch_target  input  ADDR_BITS  byte target; bits [1:0] ignored
instr_ready  input  1  core has consumed instr this cycle
instr  output  32  current instruction word
instr_valid  output  1  instr holds a valid word
next_instr  output  32  following sequential word
next_valid  output  1  next_instr holds a valid word
pc  output  ADDR_BITS  byte address of instr, word aligned

Behaviour:
- Reset values: spi_select=1, spi_clk_en=0, spi_mosi=0, instr_valid=0, next_valid=0, instr=0, next_instr=0, pc=RESET_ADDR. The FSM enters GAP with fetch address RESET_ADDR.
- FSM states GAP, CMD, ADDR, DATA. A 6-bit bit counter is used in CMD, ADDR and DATA.
- GAP:
  - spi_select=1, spi_clk_en=0.
  - Stays for CS_GAP_CYCLES cycles, then goes to CMD.
- CMD:
  - spi_select=0, spi_clk_en=1.
  - 8 cycles driving 0x03, MSB first.
  - Then goes to ADDR.
- ADDR:
  - 24 cycles driving the fetch address MSB first.
  - Address bits above ADDR_BITS are zero; bits [1:0] are forced to 0.
  - Then goes to DATA.
- DATA:
  - One spi_miso bit per enabled cycle.
  - Flash byte order is little-endian, bits MSB first within each byte.
  - The first byte received becomes word[7:0]; the fourth becomes word[31:24].
  - After 32 bits the word is written to the buffer.
  - Streaming continues with the next sequential word; the FSM does not leave DATA.
  - spi_mosi=0 throughout DATA.
- Buffer write order:
  - Into instr if !instr_valid.
  - Otherwise into next_instr.
  - If instr_ready completes in the same cycle, the old next_instr moves to instr and the new word goes to the freed slot.
- Stall:
  - At a word boundary (bit counter 0 in DATA), spi_clk_en=0 while both slots are valid and instr_ready=0.
  - spi_select stays low during the stall; the flash holds its position.
  - The stall never occurs mid-word.
- instr_ready with instr_valid=1:
  - next_instr shifts into instr and next_valid clears, unless a word completes in the same cycle.
  - pc increments by 4, modulo 2^ADDR_BITS.
- instr_ready with instr_valid=0 is ignored.
- branch, applied the following cycle:
  - Both valids clear and the partial word is discarded.
  - pc = {branch_target[ADDR_BITS-1:2], 2'b00}; the fetch address is set to the same value.
  - The FSM goes to GAP, so spi_select is high the next cycle.
- branch has priority over instr_ready and over a word completing in the same cycle.
- branch during GAP restarts the gap count with the new target.
- Branch-to-valid latency is CS_GAP_CYCLES + 64 cycles (8 command + 24 address + 32 data), then instr_valid=1.
- Address wrap: from the top word the fetch wraps to 0, matching the flash's sequential wrap; pc wraps identically.
- rst asserted mid-transaction: all outputs take reset values on the next edge. The transaction is abandoned and the FSM restarts from GAP.

Decomposition:
- Shared package holds:
  - SPI_CMD_READ = 8'h03
  - the FSM state enum (GAP, CMD, ADDR, DATA)
  - bit-count constants CMD_BITS=8, ADDR_FIELD_BITS=24, WORD_BITS=32
- One sub-module, nanov_fetch_buffer: 2-entry word buffer with valids, write/consume/flush, and slot promotion.
- The FSM, shift registers and pc stay in the top module.

Test Plan:
1. Reset release, flash model holding words 0x00000013 and 0x00A00093 at address 0:
   - spi_select falls after 2 cycles; MOSI carries 0x03 then 0x000000.
   - instr=0x00000013 and instr_valid=1 at cycle 66; next_instr=0x00A00093 32 cycles later.
2. No instr_ready for 200 cycles:
   - spi_clk_en=0 from the word boundary after the second word; spi_select stays 0.
   - One instr_ready pulse resumes SCK the next cycle; pc steps 0 to 4.
3. branch with branch_target=0x000123 while streaming:
   - Valids clear next cycle, spi_select=1 for 2 cycles.
   - Address phase sends 0x000120; pc=0x000120; first word valid 66 cycles after the branch.
4. branch and instr_ready in the same cycle as a word completes:
   - The word is dropped, pc = branch target, no valid set until the refetch completes.
5. RESET_ADDR=0xFFFFFC, ADDR_BITS=24:
   - Words at 0xFFFFFC then 0x000000 are fetched in sequence; pc reads 0xFFFFFC then 0x000000.
6. rst pulsed in the middle of the ADDR phase:
   - spi_select=1 on the next edge and all valids 0.
   - Fetch restarts with the full 0x03 + RESET_ADDR sequence.
